// File: rtl/gate_bist_if.sv
// Host-side control/status bundle for the gate BIST sequencer.
interface gate_bist_if #(
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       fail_idx;

  modport master (output start, input busy, done, pass, err_count, fail_idx);
  modport slave  (input start, output busy, done, pass, err_count, fail_idx);
endinterface

// File: rtl/gate_bist.sv
// BIST sequencer: drives LFSR vectors into an inverter under test, waits a
// settle window, checks the synchronized output and reports mismatches.
module gate_bist #(
  parameter int unsigned N_VECTORS     = 64,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned ERR_W         = 8,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_bist_if.slave      bus,
  output logic            a_out,
  input  logic            s_in
);

  localparam logic [7:0]       SEED    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam int unsigned      SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    CNT_END = SW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       LAST    = 8'(N_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             a_q, a_d;
  logic [7:0]       vec_q, vec_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       fidx_q, fidx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [1:0]       sync_q, sync_d;

  logic [7:0]       lfsr_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      a_q     <= 1'b0;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sync_q  <= sync_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    a_d      = a_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    sync_d   = {sync_q[0], s_in};
    // Taps x^8,x^6,x^5,x^4 map to bits 0,2,3,4 when shifting toward bit 0
    lfsr_nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4], lfsr_q[7:1]};
    mismatch = (sync_q[1] != ~a_q);
    err_nxt  = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          lfsr_d  = SEED;
          a_d     = SEED[0];
          vec_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CNT_END) state_d = CHECK;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      CHECK: begin
        // err_q only ever grows, so zero means no mismatch seen yet this run
        if (mismatch) begin
          if (err_q != ERR_MAX) err_nxt = err_q + 1'b1;
          if (err_q == '0)      fidx_d  = vec_q;
        end
        err_d = err_nxt;
        if (vec_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_nxt == '0);
        end else begin
          lfsr_d  = lfsr_nxt;
          a_d     = lfsr_nxt[0];
          vec_d   = vec_q + 8'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a_out         = a_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_idx  = fidx_q;

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist with behavioural inverter/fault models.
module tb_gate_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDEAL, M_BUF, M_STUCK1, M_SLOW} gmode_t;
  gmode_t mode0 = M_IDEAL;

  gate_bist_if #(.ERR_W(8)) bus0();
  gate_bist_if #(.ERR_W(4)) bus1();
  gate_bist_if #(.ERR_W(8)) bus2();

  logic a0, a1, a2;
  logic s0, s1, s2;
  logic [5:0] d0 = '0;
  logic       d1 = 1'b0;
  logic [5:0] d2 = '0;

  gate_bist u0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .a_out(a0), .s_in(s0));
  gate_bist #(.ERR_W(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .a_out(a1), .s_in(s1));
  gate_bist #(.SETTLE_CYCLES(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .a_out(a2), .s_in(s2));

  always @(posedge clk) begin
    d0 <= {d0[4:0], a0};
    d1 <= a1;
    d2 <= {d2[4:0], a2};
  end

  always_comb begin
    s0 = ~d0[0];
    case (mode0)
      M_IDEAL:  s0 = ~d0[0];
      M_BUF:    s0 = d0[0];
      M_STUCK1: s0 = 1'b1;
      M_SLOW:   s0 = ~d0[5];
      default:  s0 = ~d0[0];
    endcase
  end
  assign s1 = d1;
  assign s2 = ~d2[5];

  logic v [64];

  typedef struct {
    gmode_t mode;
    bit     mid_start;
    int     exp_err;
    bit     exp_pass;
    int     exp_fidx;
  } row_t;
  row_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic run0(input int r, input bit mid, input int exp_err,
                      input bit exp_pass, input int exp_fidx);
    int  k;
    int  aerr;
    bit  seen;
    k = 0; aerr = 0; seen = 1'b0;
    @(posedge clk); #1 bus0.start = 1'b1;
    @(posedge clk); #1 bus0.start = 1'b0;
    chk($sformatf("row%0d busy_after_start", r), bus0.busy, 1);
    if (a0 !== v[0]) aerr++;
    while (!seen && k < 1000) begin
      @(posedge clk); #1; k++;
      bus0.start = (mid && k == 50);
      if (bus0.done) seen = 1'b1;
      else if (k % 5 == 0 && k < 320 && a0 !== v[k/5]) aerr++;
    end
    chk($sformatf("row%0d done_latency", r), k, 320);
    chk($sformatf("row%0d a_out_sequence_errs", r), aerr, 0);
    chk($sformatf("row%0d err_count", r), bus0.err_count, exp_err);
    chk($sformatf("row%0d pass", r), bus0.pass, exp_pass);
    chk($sformatf("row%0d fail_idx", r), bus0.fail_idx, exp_fidx);
    chk($sformatf("row%0d busy_at_done", r), bus0.busy, 0);
  endtask

  initial begin
    logic [7:0] s;
    logic       prev;
    int ones, trans, first_one, first_trans, k;

    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;

    s = 8'hA5;
    for (int i = 0; i < 64; i++) begin
      v[i] = s[0];
      s = {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
    end
    ones = 0; trans = 0; first_one = -1; first_trans = -1; prev = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) begin ones++; if (first_one < 0) first_one = i; end
      if (v[i] != prev) begin trans++; if (first_trans < 0) first_trans = i; end
      prev = v[i];
    end

    tbl[0] = '{M_IDEAL,  1'b0, 0,     1'b1, 0};
    tbl[1] = '{M_BUF,    1'b0, 64,    1'b0, 0};
    tbl[2] = '{M_STUCK1, 1'b0, ones,  1'b0, first_one};
    tbl[3] = '{M_SLOW,   1'b0, trans, 1'b0, first_trans};
    tbl[4] = '{M_IDEAL,  1'b1, 0,     1'b1, 0};

    repeat (3) @(posedge clk); #1;
    chk("reset a_out", a0, 0);
    chk("reset busy", bus0.busy, 0);
    chk("reset done", bus0.done, 0);
    chk("reset pass", bus0.pass, 0);
    chk("reset err_count", bus0.err_count, 0);
    chk("reset fail_idx", bus0.fail_idx, 0);
    #1 rst_n = 1'b1;

    for (int r = 0; r < 5; r++) begin
      mode0 = tbl[r].mode;
      do_reset();
      run0(r, tbl[r].mid_start, tbl[r].exp_err, tbl[r].exp_pass, tbl[r].exp_fidx);
    end

    repeat (4) @(posedge clk); #1;
    chk("done_hold done", bus0.done, 1);
    chk("done_hold pass", bus0.pass, 1);

    // Abort a faulty run mid-way, then a clean ideal run must follow
    mode0 = M_BUF;
    do_reset();
    @(posedge clk); #1 bus0.start = 1'b1;
    @(posedge clk); #1 bus0.start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("midrun err_nonzero", (bus0.err_count != 0), 1);
    rst_n = 1'b0;
    #1;
    chk("abort a_out", a0, 0);
    chk("abort busy", bus0.busy, 0);
    chk("abort done", bus0.done, 0);
    chk("abort pass", bus0.pass, 0);
    chk("abort err_count", bus0.err_count, 0);
    chk("abort fail_idx", bus0.fail_idx, 0);
    mode0 = M_IDEAL;
    do_reset();
    run0(5, 1'b0, 0, 1'b1, 0);

    // start held high: restart from DONE on the first edge
    @(posedge clk); #1 bus0.start = 1'b1;
    @(posedge clk); #1;
    k = 0;
    while (!bus0.done && k < 1000) begin @(posedge clk); #1; k++; end
    chk("held_start done_latency", k, 320);
    @(posedge clk); #1;
    chk("held_start done_one_cycle", bus0.done, 0);
    chk("held_start busy_again", bus0.busy, 1);
    bus0.start = 1'b0;

    do_reset();
    @(posedge clk); #1 bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
    k = 0;
    while (!bus1.done && k < 1000) begin @(posedge clk); #1; k++; end
    chk("sat done_latency", k, 320);
    chk("sat err_count", bus1.err_count, 15);
    chk("sat pass", bus1.pass, 0);
    chk("sat fail_idx", bus1.fail_idx, 0);

    @(posedge clk); #1 bus2.start = 1'b1;
    @(posedge clk); #1 bus2.start = 1'b0;
    k = 0;
    while (!bus2.done && k < 2000) begin @(posedge clk); #1; k++; end
    chk("slow8 done_latency", k, 640);
    chk("slow8 err_count", bus2.err_count, 0);
    chk("slow8 pass", bus2.pass, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Built-in self-test sequencer for the switch-level gate cells, starting with the transistor-level inverter.
- Drives the inverter input (upstream stage) with pseudo-random vectors and samples the inverter output (downstream stage) after a settle window.
- Checks each sample against the expected inverted value, counts mismatches and reports pass/fail.
- Sits between board-level control (button/host start) and the gate-under-test pads.

Parameters:
- N_VECTORS, 64: vectors applied per run; range 2..256.
- SETTLE_CYCLES, 3: cycles waited after driving each vector before checking; minimum 2, which covers the input synchronizer.
- ERR_W, 8: error counter width.
- LFSR_SEED, 8'hA5: 8-bit LFSR seed. A value of 0 is replaced by 8'h01.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request, sampled on clk.
- a_out  out  1  registered stimulus to the gate input a.
- s_in  in  1  gate output s; asynchronous to clk.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next accepted start.
- pass  out  1  valid when done=1; high when err_count==0.
- err_count  out  ERR_W  mismatch count, saturating.
- fail_idx  out  8  index of the first mismatching vector; 0 if none.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state=IDLE.
  - a_out=0, busy=0, done=0, pass=0, err_count=0, fail_idx=0.
  - lfsr=seed; vector counter, settle counter and both synchronizer flops = 0.
- Input synchronizer: s_in passes through 2 flops (s_sync). All comparisons use s_sync only.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts toward bit 0. The stimulus bit is lfsr[0].
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE / DONE:
  - start=1 at an edge is accepted.
  - On that same edge: lfsr<=seed, a_out<=seed[0], vec<=0, err_count<=0, fail_idx<=0, done<=0, pass<=0, busy<=1, state<=DRIVE.
  - In DONE, done, pass, err_count and fail_idx hold until a start is accepted.
- DRIVE: one cycle; settle counter cleared; next state SETTLE.
- SETTLE: exactly SETTLE_CYCLES cycles; next state CHECK.
- CHECK: one cycle; mismatch means s_sync != ~a_out.
  - On mismatch: err_count increments, saturating at 2^ERR_W-1.
  - If this is the first mismatch of the run: fail_idx<=vec.
  - If vec==N_VECTORS-1: state<=DONE, busy<=0, done<=1, pass<=(final err_count==0). The final count includes the current check.
  - Otherwise: lfsr<=next(lfsr), a_out<=next(lfsr)[0], vec<=vec+1, state<=DRIVE.
- a_out changes only on the start-accept edge and on CHECK->DRIVE edges. In IDLE it holds 0; in DONE it holds the last vector.
- Timing:
  - Per-vector time = SETTLE_CYCLES+2 cycles.
  - done rises N_VECTORS*(SETTLE_CYCLES+2) cycles after the start-accept edge.
- start while busy: ignored, no effect on the run.
- start held high continuously: a new run begins on the first edge in DONE. done is visible for 1 cycle.
- Saturation: err_count sticks at its maximum value. fail_idx is unaffected by saturation.
- Reset mid-run: aborts immediately to reset values. No partial results are retained.

Test Plan:
- Ideal inverter model (s_in = ~a_out, 1-cycle delay), defaults:
  - start pulse -> busy=1 the next cycle.
  - done=1 exactly 320 cycles after the accept edge.
  - pass=1, err_count=0, fail_idx=0.
- Buffer fault (s_in = a_out), defaults -> err_count=64, pass=0, fail_idx=0. a_out sequence matches the LFSR reference model bit for bit.
- Saturation with buffer fault, ERR_W=4 -> err_count=15 at done, pass=0.
- Slow gate model (6-cycle delay):
  - SETTLE_CYCLES=3 -> err_count>0. fail_idx equals the first vector whose value differs from its predecessor, per the reference model.
  - SETTLE_CYCLES=8 -> pass=1.
- Control corner cases:
  - Pulse start at cycle 50 of a run -> completion time and results are unchanged.
  - Drive rst_n low at cycle 100 -> all outputs 0 immediately.
  - Release rst_n, then start -> a full clean run, pass=1.
- Stuck-at-1 output (s_in=1) -> err_count equals the count of 1s in the first 64 lfsr[0] values. pass=0.
